// File: rtl/switch_input_device.sv
// Switch input peripheral: 2-flop sync, debounce, and a bus-readable data/status register pair.
// Commit lands DEBOUNCE_CYCLES+3 edges after a pin change; bus access is never stalled (reads are combinational).
module switch_input_device #(
    parameter int                   BIT_WIDTH       = 32,
    parameter int                   SW_WIDTH        = 10,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter logic [BIT_WIDTH-1:0] DATA_ADDR       = BIT_WIDTH'(32'hF0000014),
    parameter logic [BIT_WIDTH-1:0] CTRL_ADDR       = BIT_WIDTH'(32'hF0000114)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] aBus,
    input  logic                 wrtEn,
    input  logic                 rdEn,
    input  logic [BIT_WIDTH-1:0] dataIn,
    output logic [BIT_WIDTH-1:0] dataOut,
    input  logic [SW_WIDTH-1:0]  swIn,
    output logic                 intr
);

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync1_q, sync1_d;
    logic [SW_WIDTH-1:0] sync2_q, sync2_d;
    logic [SW_WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] sdata_q, sdata_d;
    logic                ready_q, ready_d;
    logic                ovr_q, ovr_d;
    logic                ie_q, ie_d;

    logic                 commit;
    logic                 rd_data;
    logic                 rd_ctrl;
    logic                 wr_ctrl;
    logic [BIT_WIDTH-1:0] sctrl;
    logic                 unused_dat;

    assign rd_data = rdEn  && (aBus == DATA_ADDR);
    assign rd_ctrl = rdEn  && (aBus == CTRL_ADDR);
    assign wr_ctrl = wrtEn && (aBus == CTRL_ADDR);

    // Only bits 8 and 2 of a control write carry meaning.
    assign unused_dat = ^{dataIn[BIT_WIDTH-1:9], dataIn[7:3], dataIn[1:0]};

    always_comb begin
        sync1_d = swIn;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != sdata_q) begin
            commit = 1'b1;
        end
        sdata_d = commit ? cand_q : sdata_q;
    end

    always_comb begin
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        if (rd_data) begin
            ready_d = 1'b0;
        end
        // A commit beats a same-edge clearing read; the consumed value is not an overrun.
        if (commit) begin
            ready_d = 1'b1;
        end
        if (wr_ctrl) begin
            ie_d = dataIn[8];
            if (!dataIn[2]) begin
                ovr_d = 1'b0;
            end
        end
        if (commit && ready_q && !rd_data) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        sctrl    = '0;
        sctrl[0] = ready_q;
        sctrl[2] = ovr_q;
        sctrl[8] = ie_q;
    end

    always_comb begin
        dataOut = '0;
        if (rd_data) begin
            dataOut = BIT_WIDTH'(sdata_q);
        end else if (rd_ctrl) begin
            dataOut = sctrl;
        end
    end

    assign intr = ready_q & ie_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            sdata_q <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sdata_q <= sdata_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

endmodule

// File: tb/tb_switch_input_device.sv
// Directed bench for switch_input_device with immediate-assertion checks.
`timescale 1ns/1ps
module tb_switch_input_device;

    localparam logic [31:0] DATA_A = 32'hF0000014;
    localparam logic [31:0] CTRL_A = 32'hF0000114;
    localparam logic [31:0] BAD_A  = 32'hF0000018;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] aBus = '0;
    logic        wrtEn = 1'b0;
    logic        rdEn = 1'b0;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;
    logic [9:0]  swIn = '0;
    logic        intr;

    int n_chk = 0;
    int n_fail = 0;

    switch_input_device #(
        .BIT_WIDTH(32), .SW_WIDTH(10), .DEBOUNCE_CYCLES(4),
        .DATA_ADDR(32'hF0000014), .CTRL_ADDR(32'hF0000114)
    ) dut (
        .clk(clk), .reset(reset), .aBus(aBus), .wrtEn(wrtEn), .rdEn(rdEn),
        .dataIn(dataIn), .dataOut(dataOut), .swIn(swIn), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Non-destructive look: strobe drops again before the next edge.
    task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        rdEn = 1'b1;
        aBus = addr;
        #1;
        check(tag, dataOut, exp);
        rdEn = 1'b0;
        aBus = '0;
    endtask

    // Read held across one edge, so a DATA read consumes ready.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        rdEn = 1'b1;
        aBus = addr;
        #1;
        check(tag, dataOut, exp);
        tick(1);
        rdEn = 1'b0;
        aBus = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        wrtEn  = 1'b1;
        aBus   = addr;
        dataIn = data;
        tick(1);
        wrtEn  = 1'b0;
        aBus   = '0;
        dataIn = '0;
    endtask

    initial begin
        // 1: reset state and idle reads
        tick(2);
        peek(CTRL_A, 32'h0, "rst_ctrl");
        check("rst_intr", {31'b0, intr}, 32'h0);
        reset = 1'b0;
        tick(20);
        peek(DATA_A, 32'h0, "idle_data");
        peek(CTRL_A, 32'h0, "idle_ctrl");
        peek(BAD_A, 32'h0, "idle_unmapped");
        check("idle_intr", {31'b0, intr}, 32'h0);

        // 3: three-cycle glitch never commits
        swIn = 10'h001;
        tick(3);
        swIn = 10'h000;
        tick(15);
        peek(CTRL_A, 32'h0, "glitch_ctrl_mid");
        tick(15);
        peek(CTRL_A, 32'h0, "glitch_ctrl");
        peek(DATA_A, 32'h0, "glitch_data");

        // 2: latency of a clean change
        swIn = 10'h2A5;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            peek(CTRL_A, 32'h0, $sformatf("lat_ctrl_e%0d", e));
        end
        tick(1);
        peek(CTRL_A, 32'h1, "lat_ctrl_e7");
        rd(DATA_A, 32'h2A5, "lat_data_rd");
        peek(CTRL_A, 32'h0, "lat_ctrl_after_rd");
        wr(DATA_A, 32'hFFF);
        wr(BAD_A, 32'h104);
        peek(DATA_A, 32'h2A5, "data_write_ignored");
        peek(CTRL_A, 32'h0, "unmapped_write_ignored");

        // 4: interrupt enable, overrun set and clear
        wr(CTRL_A, 32'h100);
        peek(CTRL_A, 32'h100, "ie_set");
        swIn = 10'h003;
        tick(6);
        check("intr_before_commit", {31'b0, intr}, 32'h0);
        tick(1);
        check("intr_after_commit", {31'b0, intr}, 32'h1);
        peek(DATA_A, 32'h3, "data_003");
        swIn = 10'h007;
        tick(7);
        peek(CTRL_A, 32'h105, "overrun_set");
        peek(DATA_A, 32'h7, "data_007");
        wr(CTRL_A, 32'h104);
        peek(CTRL_A, 32'h105, "ovr_write1_ignored");
        wr(CTRL_A, 32'h100);
        peek(CTRL_A, 32'h101, "ovr_cleared");
        rd(DATA_A, 32'h7, "rd_007");
        check("intr_after_rd", {31'b0, intr}, 32'h0);
        peek(CTRL_A, 32'h100, "ctrl_after_rd");

        // 5: clearing read on the commit edge
        swIn = 10'h011;
        tick(7);
        peek(CTRL_A, 32'h101, "ready_011");
        swIn = 10'h0F0;
        tick(6);
        rd(DATA_A, 32'h011, "rd_on_commit");
        peek(CTRL_A, 32'h101, "commit_beats_rd");
        peek(DATA_A, 32'h0F0, "data_0F0");
        check("intr_0F0", {31'b0, intr}, 32'h1);

        // commit-set overrun beats a same-edge clearing write
        swIn = 10'h0AA;
        tick(6);
        wr(CTRL_A, 32'h100);
        peek(CTRL_A, 32'h105, "set_beats_clear");
        wr(CTRL_A, 32'h000);
        peek(CTRL_A, 32'h001, "ie_and_ovr_cleared");
        check("intr_ie_off", {31'b0, intr}, 32'h0);

        // 6: async reset mid-debounce
        swIn = 10'h3FF;
        tick(5);
        reset = 1'b1;
        #1;
        peek(CTRL_A, 32'h0, "rst_mid_ctrl");
        peek(DATA_A, 32'h0, "rst_mid_data");
        tick(3);
        reset = 1'b0;
        tick(6);
        peek(CTRL_A, 32'h0, "rel_ctrl_e14");
        tick(1);
        peek(CTRL_A, 32'h1, "rel_ctrl_e15");
        peek(DATA_A, 32'h3FF, "rel_data_e15");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
